// File: rtl/alu_seq_mc.sv
// Registered multi-cycle ALU with a valid/ready request side and a held result/status side.
// Five operations; MUL runs as an m-step shift-add, every other opcode completes on the accept edge.
module alu_seq_mc #(
  parameter int unsigned m = 8,
  parameter int unsigned n = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [n-1:0] i_op,
  input  logic [m-1:0] i_argA,
  input  logic [m-1:0] i_argB,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [m-1:0] o_result,
  output logic [3:0]   o_status
);

  localparam int unsigned cw = $clog2(m) + 1;

  localparam logic [n-1:0] op_sub    = n'(0);
  localparam logic [n-1:0] op_lt     = n'(1);
  localparam logic [n-1:0] op_clrbit = n'(2);
  localparam logic [n-1:0] op_zm2u2  = n'(3);
  localparam logic [n-1:0] op_mul    = n'(4);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

  state_t           state_q;
  logic [cw-1:0]    cnt_q;
  logic [2*m-1:0]   mcand_q;
  logic [2*m-1:0]   acc_q;
  logic [m-1:0]     mplier_q;

  logic [m-1:0]     op_res;
  logic             op_f0;
  logic [m-1:0]     diff;
  logic [m-1:0]     mag;
  logic [2*m-1:0]   acc_d;

  function automatic logic [3:0] flags(logic [m-1:0] r, logic f0);
    return {&r, ~^r, r[m-1], f0};
  endfunction

  // Result of the single-cycle opcodes, taken straight from the request inputs.
  always_comb begin
    op_res = '0;
    op_f0  = 1'b0;
    diff   = i_argA - i_argB;
    mag    = {1'b0, i_argA[m-2:0]};
    case (i_op)
      op_sub: begin
        op_res = diff;
        op_f0  = (i_argA[m-1] != i_argB[m-1]) && (diff[m-1] != i_argA[m-1]);
      end
      op_lt: begin
        op_res = {{(m-1){1'b0}}, ($signed(i_argA) < $signed(i_argB))};
      end
      op_clrbit: begin
        if (i_argB < m'(m)) begin
          op_res = i_argA & ~(m'(1) << i_argB);
        end else begin
          op_res = i_argA;
          op_f0  = 1'b1;
        end
      end
      op_zm2u2: begin
        if (!i_argA[m-1]) begin
          op_res = i_argA;
        end else if (mag == '0) begin
          op_f0  = 1'b1;
        end else begin
          op_res = m'(0) - mag;
        end
      end
      default: begin
        op_f0 = 1'b1;
      end
    endcase
  end

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= StIdle;
      o_ready  <= 1'b1;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_status <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_valid) begin
            o_ready <= 1'b0;
            if (i_op == op_mul) begin
              mcand_q  <= {{m{1'b0}}, i_argA};
              mplier_q <= i_argB;
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= StBusy;
            end else begin
              o_result <= op_res;
              o_status <= flags(op_res, op_f0);
              o_valid  <= 1'b1;
              state_q  <= StDone;
            end
          end
        end
        StBusy: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + cw'(1);
          // Last of m steps: the upper half of the product only feeds the overflow flag.
          if (cnt_q == cw'(m - 1)) begin
            o_result <= acc_d[m-1:0];
            o_status <= flags(acc_d[m-1:0], |acc_d[2*m-1:m]);
            o_valid  <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          o_ready <= 1'b1;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
